// File: rtl/rot_ctrl.sv
// Rotate-core sequencer: walks the source image one pixel at a time and issues one DMA read
// and then one DMA write to the rotated destination address, with done-interrupt status.
module rot_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16,
  parameter int PIX_W  = 8
) (
  input  logic              I_ROTCTRL_PCLK,
  input  logic              I_ROTCTRL_PRESET_N,
  input  logic [ADDR_W-1:0] I_ROTCTRL_SRC_IMG,
  input  logic [ADDR_W-1:0] I_ROTCTRL_DST_IMG,
  input  logic [DIM_W-1:0]  I_ROTCTRL_IMG_H,
  input  logic [DIM_W-1:0]  I_ROTCTRL_IMG_W,
  input  logic [1:0]        I_ROTCTRL_MODE,
  input  logic              I_ROTCTRL_DIR,
  input  logic              I_ROTCTRL_START,
  input  logic              I_ROTCTRL_SOFT_RST,
  input  logic              I_ROTCTRL_INTR_MASK,
  input  logic              I_ROTCTRL_INTR_CLEAR,
  output logic [DIM_W-1:0]  O_ROTCTRL_NEW_H,
  output logic [DIM_W-1:0]  O_ROTCTRL_NEW_W,
  output logic              O_ROTCTRL_BEF_MASK,
  output logic              O_ROTCTRL_AFT_MASK,
  output logic              O_ROTCTRL_INTR,
  output logic              O_ROTCTRL_BUSY,
  output logic              O_ROTCTRL_RD_REQ,
  output logic [ADDR_W-1:0] O_ROTCTRL_RD_ADDR,
  input  logic              I_ROTCTRL_RD_ACK,
  input  logic [PIX_W-1:0]  I_ROTCTRL_RD_DATA,
  output logic              O_ROTCTRL_WR_REQ,
  output logic [ADDR_W-1:0] O_ROTCTRL_WR_ADDR,
  output logic [PIX_W-1:0]  O_ROTCTRL_WR_DATA,
  input  logic              I_ROTCTRL_WR_ACK
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_RD_REQ, S_WR_REQ, S_NEXT, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [DIM_W-1:0]  D_ONE = DIM_W'(1);

  state_t            r_state, w_state_nxt;
  logic              r_start_q;
  logic [ADDR_W-1:0] r_src, r_dst;
  logic [DIM_W-1:0]  r_h, r_w, r_y, r_x, r_new_h, r_new_w;
  logic [1:0]        r_angle;
  logic [PIX_W-1:0]  r_pix;
  logic              r_bef;

  logic              w_rst, w_start_edge, w_x_end, w_last;
  logic [1:0]        w_angle;
  logic [ADDR_W-1:0] w_x, w_y, w_h, w_w, w_xr, w_yr, w_idx;

  // Soft reset behaves exactly like the port reset.
  assign w_rst        = !I_ROTCTRL_PRESET_N || I_ROTCTRL_SOFT_RST;
  assign w_start_edge = I_ROTCTRL_START && !r_start_q;
  assign w_angle      = I_ROTCTRL_DIR ? (2'd0 - I_ROTCTRL_MODE) : I_ROTCTRL_MODE;
  assign w_x_end      = (r_x == r_w - D_ONE);
  assign w_last       = w_x_end && (r_y == r_h - D_ONE);

  assign w_x  = ADDR_W'(r_x);
  assign w_y  = ADDR_W'(r_y);
  assign w_h  = ADDR_W'(r_h);
  assign w_w  = ADDR_W'(r_w);
  assign w_xr = w_w - w_x - A_ONE;
  assign w_yr = w_h - w_y - A_ONE;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_idx = '0;
    case (r_angle)
      2'd0:    w_idx = w_y  * w_w + w_x;
      2'd1:    w_idx = w_x  * w_h + w_yr;
      2'd2:    w_idx = w_yr * w_w + w_xr;
      default: w_idx = w_xr * w_h + w_y;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start_edge) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = (I_ROTCTRL_IMG_H == '0 || I_ROTCTRL_IMG_W == '0) ? S_DONE : S_RD_REQ;
      S_RD_REQ: if (I_ROTCTRL_RD_ACK) w_state_nxt = S_WR_REQ;
      S_WR_REQ: if (I_ROTCTRL_WR_ACK) w_state_nxt = S_NEXT;
      S_NEXT:   w_state_nxt = w_last ? S_DONE : S_RD_REQ;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_ROTCTRL_PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge I_ROTCTRL_PCLK) begin
    if (w_rst) begin
      r_start_q <= 1'b0;
      r_src     <= '0;
      r_dst     <= '0;
      r_h       <= '0;
      r_w       <= '0;
      r_y       <= '0;
      r_x       <= '0;
      r_new_h   <= '0;
      r_new_w   <= '0;
      r_angle   <= '0;
      r_pix     <= '0;
      r_bef     <= 1'b0;
    end else begin
      r_start_q <= I_ROTCTRL_START;
      case (r_state)
        S_SETUP: begin
          r_src   <= I_ROTCTRL_SRC_IMG;
          r_dst   <= I_ROTCTRL_DST_IMG;
          r_h     <= I_ROTCTRL_IMG_H;
          r_w     <= I_ROTCTRL_IMG_W;
          r_angle <= w_angle;
          r_new_h <= w_angle[0] ? I_ROTCTRL_IMG_W : I_ROTCTRL_IMG_H;
          r_new_w <= w_angle[0] ? I_ROTCTRL_IMG_H : I_ROTCTRL_IMG_W;
          r_y     <= '0;
          r_x     <= '0;
        end
        S_RD_REQ: if (I_ROTCTRL_RD_ACK) r_pix <= I_ROTCTRL_RD_DATA;
        S_NEXT: begin
          if (w_x_end) begin
            r_x <= '0;
            r_y <= r_y + D_ONE;
          end else begin
            r_x <= r_x + D_ONE;
          end
        end
        default: ;
      endcase
      // Completion beats a simultaneous clear.
      if (r_state == S_DONE)         r_bef <= 1'b1;
      else if (I_ROTCTRL_INTR_CLEAR) r_bef <= 1'b0;
    end
  end

  assign O_ROTCTRL_NEW_H    = r_new_h;
  assign O_ROTCTRL_NEW_W    = r_new_w;
  assign O_ROTCTRL_BEF_MASK = r_bef;
  assign O_ROTCTRL_AFT_MASK = r_bef && !I_ROTCTRL_INTR_MASK;
  assign O_ROTCTRL_INTR     = r_bef && !I_ROTCTRL_INTR_MASK;
  assign O_ROTCTRL_BUSY     = (r_state != S_IDLE);
  assign O_ROTCTRL_RD_REQ   = (r_state == S_RD_REQ);
  assign O_ROTCTRL_RD_ADDR  = r_src + w_y * w_w + w_x;
  assign O_ROTCTRL_WR_REQ   = (r_state == S_WR_REQ);
  assign O_ROTCTRL_WR_ADDR  = r_dst + w_idx;
  assign O_ROTCTRL_WR_DATA  = r_pix;

endmodule

// File: tb/tb_rot_ctrl.sv
// Scoreboard bench for rot_ctrl: a geometric rotation model queues the expected DMA traffic,
// a DMA responder with random stalls serves requests, and a monitor pops and compares.
module tb_rot_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, soft_rst, intr_mask, intr_clear, dir;
  logic [31:0] src_img, dst_img;
  logic [15:0] img_h, img_w, new_h, new_w;
  logic [1:0]  mode;
  logic        bef, aft, intr, busy;
  logic        rd_req, rd_ack, wr_req, wr_ack;
  logic [31:0] rd_addr, wr_addr;
  logic [7:0]  rd_data, wr_data;

  rot_ctrl #(.ADDR_W(32), .DIM_W(16), .PIX_W(8)) dut (
    .I_ROTCTRL_PCLK(clk),             .I_ROTCTRL_PRESET_N(rst_n),
    .I_ROTCTRL_SRC_IMG(src_img),      .I_ROTCTRL_DST_IMG(dst_img),
    .I_ROTCTRL_IMG_H(img_h),          .I_ROTCTRL_IMG_W(img_w),
    .I_ROTCTRL_MODE(mode),            .I_ROTCTRL_DIR(dir),
    .I_ROTCTRL_START(start),          .I_ROTCTRL_SOFT_RST(soft_rst),
    .I_ROTCTRL_INTR_MASK(intr_mask),  .I_ROTCTRL_INTR_CLEAR(intr_clear),
    .O_ROTCTRL_NEW_H(new_h),          .O_ROTCTRL_NEW_W(new_w),
    .O_ROTCTRL_BEF_MASK(bef),         .O_ROTCTRL_AFT_MASK(aft),
    .O_ROTCTRL_INTR(intr),            .O_ROTCTRL_BUSY(busy),
    .O_ROTCTRL_RD_REQ(rd_req),        .O_ROTCTRL_RD_ADDR(rd_addr),
    .I_ROTCTRL_RD_ACK(rd_ack),        .I_ROTCTRL_RD_DATA(rd_data),
    .O_ROTCTRL_WR_REQ(wr_req),        .O_ROTCTRL_WR_ADDR(wr_addr),
    .O_ROTCTRL_WR_DATA(wr_data),      .I_ROTCTRL_WR_ACK(wr_ack)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic [31:0] rd_q[$];
  wr_t         wr_q[$];
  logic [7:0]  src_mem[logic [31:0]];
  logic [7:0]  dst_mem[logic [31:0]];
  logic [7:0]  exp_dst[logic [31:0]];

  int n_checks = 0;
  int n_errors = 0;
  int max_stall = 0;
  bit spurious = 1'b0;
  bit rd_seen_any = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // DMA responder: a fresh request waits 0..max_stall cycles before the ack.
  int rd_wait, wr_wait;
  bit rd_pend = 1'b0, wr_pend = 1'b0;
  initial begin
    rd_ack = 1'b0; wr_ack = 1'b0; rd_data = 8'h00;
  end
  always @(posedge clk) begin
    #1;
    if (rd_req) begin
      if (!rd_pend) begin rd_pend = 1'b1; rd_wait = $urandom_range(max_stall, 0); end
      if (rd_wait == 0) begin
        rd_ack  = 1'b1;
        rd_data = src_mem.exists(rd_addr) ? src_mem[rd_addr] : 8'hEE;
      end else begin
        rd_ack = 1'b0;
        rd_wait--;
      end
    end else begin
      rd_pend = 1'b0;
      rd_ack  = spurious && ($urandom_range(3, 0) == 0);
      rd_data = 8'h5A;
    end
    if (wr_req) begin
      if (!wr_pend) begin wr_pend = 1'b1; wr_wait = $urandom_range(max_stall, 0); end
      if (wr_wait == 0) wr_ack = 1'b1;
      else begin wr_ack = 1'b0; wr_wait--; end
    end else begin
      wr_pend = 1'b0;
      wr_ack  = spurious && ($urandom_range(3, 0) == 0);
    end
  end

  // Monitor: compares each completed handshake against the head of the expected queues.
  bit          rd_seen = 1'b0, wr_seen = 1'b0;
  logic [31:0] rd_first, wr_first_a;
  logic [7:0]  wr_first_d;
  always @(negedge clk) begin
    if (rd_req || wr_req) check("rd_wr_exclusive", 64'(rd_req & wr_req), 64'd0);
    if (rd_req) begin
      rd_seen_any = 1'b1;
      if (rd_seen) check("rd_addr_stable", 64'(rd_addr), 64'(rd_first));
      else begin rd_seen = 1'b1; rd_first = rd_addr; end
      if (rd_ack) begin
        if (rd_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
        else check("rd_addr", 64'(rd_addr), 64'(rd_q.pop_front()));
        rd_seen = 1'b0;
      end
    end else rd_seen = 1'b0;
    if (wr_req) begin
      if (wr_seen) begin
        check("wr_addr_stable", 64'(wr_addr), 64'(wr_first_a));
        check("wr_data_stable", 64'(wr_data), 64'(wr_first_d));
      end else begin
        wr_seen = 1'b1; wr_first_a = wr_addr; wr_first_d = wr_data;
      end
      if (wr_ack) begin
        if (wr_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
        else check("wr_addr_data", 64'({wr_addr, wr_data}), 64'(wr_q.pop_front()));
        dst_mem[wr_addr] = wr_data;
        wr_seen = 1'b0;
      end
    end else wr_seen = 1'b0;
  end

  // Reference model: rotate pixel (y,x) geometrically into the destination raster.
  task automatic prep_job(input int h, input int w, input logic [1:0] md, input logic dr,
                          input logic [31:0] src, input logic [31:0] dst, input bit seq,
                          output int nh, output int nw);
    int a, r, c;
    logic [7:0]  pix;
    logic [31:0] sa, da;
    src_mem.delete(); dst_mem.delete(); exp_dst.delete();
    rd_q.delete(); wr_q.delete();
    a  = dr ? (4 - int'(md)) % 4 : int'(md);
    nh = (a % 2 == 1) ? w : h;
    nw = (a % 2 == 1) ? h : w;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        pix = seq ? 8'(y * w + x) : 8'($urandom);
        sa  = src + 32'(y * w + x);
        src_mem[sa] = pix;
        rd_q.push_back(sa);
        case (a)
          0:       begin r = y;         c = x;         end
          1:       begin r = x;         c = h - 1 - y; end
          2:       begin r = h - 1 - y; c = w - 1 - x; end
          default: begin r = w - 1 - x; c = y;         end
        endcase
        da = dst + 32'(r * nw + c);
        wr_q.push_back({da, pix});
        exp_dst[da] = pix;
      end
    end
  endtask

  task automatic run_job(input int h, input int w, input logic [1:0] md, input logic dr,
                         input logic [31:0] src, input logic [31:0] dst, input bit seq,
                         input bit timed, input bit mid_pulse, input bit hold_clear);
    int nh, nw, cyc, p;
    bit done;
    p = h * w;
    prep_job(h, w, md, dr, src, dst, seq, nh, nw);
    @(negedge clk);
    src_img = src; dst_img = dst; img_h = 16'(h); img_w = 16'(w); mode = md; dir = dr;
    start = 1'b0; intr_clear = 1'b1;
    @(negedge clk);
    if (!hold_clear) begin
      intr_clear = 1'b0;
      check("pre_clear_bef", 64'(bef), 64'd0);
    end
    @(negedge clk);
    start = 1'b1; rd_seen_any = 1'b0;
    @(negedge clk);
    cyc = 1;
    check("setup_busy", 64'(busy), 64'd1);
    check("setup_no_rd", 64'(rd_req), 64'd0);
    done = 1'b0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2 && p > 0) check("rd_latency", 64'(rd_req), 64'd1);
      if (cyc == 3) begin
        src_img = $urandom; dst_img = $urandom; img_h = 16'($urandom);
        img_w = 16'($urandom); mode = 2'($urandom); dir = 1'($urandom);
      end
      if (mid_pulse && cyc == 4) start = 1'b0;
      if (mid_pulse && cyc == 6) start = 1'b1;
      if (bef) done = 1'b1;
    end
    check("job_done", 64'(done), 64'd1);
    if (timed) check("job_cycles", 64'(cyc), 64'(3 + 3 * p));
    check("busy_low_after_done", 64'(busy), 64'd0);
    check("intr_raw_set", 64'(intr), 64'd1);
    check("aft_mask_set", 64'(aft), 64'd1);
    check("new_h", 64'(new_h), 64'(nh));
    check("new_w", 64'(new_w), 64'(nw));
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    if (p == 0) check("no_rd_for_empty", 64'(rd_seen_any), 64'd0);
    foreach (exp_dst[a])
      check("dst_byte", dst_mem.exists(a) ? 64'(dst_mem[a]) : 64'h100, 64'(exp_dst[a]));
  endtask

  task automatic check_dst6(input string name, input logic [31:0] base, input logic [47:0] exp);
    logic [31:0] a;
    for (int i = 0; i < 6; i++) begin
      a = base + 32'(i);
      check(name, dst_mem.exists(a) ? 64'(dst_mem[a]) : 64'h100, 64'(exp[47 - 8 * i -: 8]));
    end
  endtask

  task automatic idle_no_retrigger(input string name);
    bit seen;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    int nh, nw, k, h, w;
    logic [31:0] s, d;
    rst_n = 1'b0; start = 1'b0; soft_rst = 1'b0; intr_mask = 1'b0; intr_clear = 1'b0;
    src_img = '0; dst_img = '0; img_h = '0; img_w = '0; mode = '0; dir = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd_req", 64'(rd_req), 64'd0);
    check("rst_wr_req", 64'(wr_req), 64'd0);
    check("rst_bef", 64'(bef), 64'd0);
    check("rst_intr", 64'(intr), 64'd0);
    check("rst_new_hw", 64'({new_h, new_w}), 64'd0);
    check("rst_addrs", 64'({rd_addr, wr_addr}), 64'd0);
    rst_n = 1'b1;

    // 90 CW, then 180, then 90 CCW, all with 1-cycle acks
    run_job(2, 3, 2'b01, 1'b0, 32'h1000, 32'h2000, 1'b1, 1'b1, 1'b0, 1'b0);
    check_dst6("t1_dst", 32'h2000, {8'd3, 8'd0, 8'd4, 8'd1, 8'd5, 8'd2});
    run_job(2, 3, 2'b10, 1'b0, 32'h1000, 32'h2000, 1'b1, 1'b1, 1'b0, 1'b0);
    check_dst6("t2_dst_180", 32'h2000, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0});
    run_job(2, 3, 2'b01, 1'b1, 32'h1000, 32'h2000, 1'b1, 1'b1, 1'b0, 1'b0);
    check_dst6("t2_dst_ccw", 32'h2000, {8'd2, 8'd5, 8'd1, 8'd4, 8'd0, 8'd3});

    // Random ack stalls and stray acks outside the request states
    max_stall = 5; spurious = 1'b1;
    run_job(2, 3, 2'b01, 1'b0, 32'h1000, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b0);
    check_dst6("t3_dst_stall", 32'h2000, {8'd3, 8'd0, 8'd4, 8'd1, 8'd5, 8'd2});

    // START held after DONE, and a START pulse mid-job, must not restart
    idle_no_retrigger("held_start_no_rerun");
    run_job(2, 3, 2'b11, 1'b0, 32'h0400, 32'h0800, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_no_retrigger("midjob_pulse_no_rerun");

    // Soft reset while a write is pending
    max_stall = 2;
    check("sr_bef_before", 64'(bef), 64'd1);
    prep_job(3, 3, 2'b01, 1'b0, 32'h3000, 32'h4000, 1'b0, nh, nw);
    @(negedge clk);
    src_img = 32'h3000; dst_img = 32'h4000; img_h = 16'd3; img_w = 16'd3; mode = 2'b01; dir = 1'b0;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    k = 0;
    while (!wr_req && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("sr_reached_wr", 64'(wr_req), 64'd1);
    soft_rst = 1'b1; start = 1'b0;
    @(negedge clk);
    check("sr_rd_req", 64'(rd_req), 64'd0);
    check("sr_wr_req", 64'(wr_req), 64'd0);
    check("sr_busy", 64'(busy), 64'd0);
    check("sr_bef", 64'(bef), 64'd0);
    check("sr_new_h", 64'(new_h), 64'd0);
    soft_rst = 1'b0;
    rd_q.delete(); wr_q.delete();
    run_job(3, 4, 2'b10, 1'b1, 32'h3000, 32'h4000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Empty image and interrupt mask/clear behaviour
    max_stall = 0; spurious = 1'b0;
    run_job(0, 5, 2'b00, 1'b0, 32'h5000, 32'h6000, 1'b0, 1'b1, 1'b0, 1'b0);
    intr_mask = 1'b1;
    @(negedge clk);
    check("masked_intr", 64'(intr), 64'd0);
    check("masked_aft", 64'(aft), 64'd0);
    check("masked_bef", 64'(bef), 64'd1);
    intr_mask = 1'b0;
    @(negedge clk);
    check("unmasked_intr", 64'(intr), 64'd1);
    intr_clear = 1'b1;
    @(negedge clk);
    intr_clear = 1'b0;
    check("clear_bef", 64'(bef), 64'd0);
    check("clear_intr", 64'(intr), 64'd0);
    run_job(4, 0, 2'b01, 1'b0, 32'h5000, 32'h6000, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("clear_after_set", 64'(bef), 64'd0);
    intr_clear = 1'b0;

    // Random jobs, the first two crossing the top of the address space
    max_stall = 3; spurious = 1'b1;
    for (int j = 0; j < 6; j++) begin
      h = $urandom_range(6, 1);
      w = $urandom_range(6, 1);
      s = (j == 0) ? 32'hFFFF_FFF0 : $urandom;
      d = (j <= 1) ? 32'hFFFF_FFF8 : $urandom;
      run_job(h, w, 2'($urandom), 1'($urandom), s, d, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
